// File: rtl/execute_muldiv_if.sv
// Request/response bundle between the execute pipeline and the multiply/divide unit.
// The slave modport is the unit's view; the master modport is the pipeline's view.
interface execute_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [XLEN-1:0]  i_data_1;
    logic [XLEN-1:0]  i_data_2;
    logic [TAG_W-1:0] i_tag;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;

    modport slave (
        input  i_valid, i_funct3, i_data_1, i_data_2, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag
    );

    modport master (
        output i_valid, i_funct3, i_data_1, i_data_2, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: one product or quotient bit per cycle
// on operand magnitudes, with the sign applied when the final result is registered.
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    execute_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_funct3;
    logic             r_neg;
    logic             r_special;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_mcand;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic             w_ready, w_accept, w_is_div, w_s1, w_s2, w_neg;
    logic             w_div0, w_ovf, w_qbit;
    logic [XLEN-1:0]  w_mag1, w_mag2, w_spec_val, w_hi_nx, w_lo_nx, w_final;
    logic [XLEN:0]    w_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_prod_c;

    // o_ready is held low while reset is asserted so every output reads zero then.
    assign w_ready  = (r_state == S_IDLE) && reset;
    assign w_accept = bus.i_valid && w_ready && !bus.i_flush;
    assign w_is_div = bus.i_funct3[2];

    assign w_s1 = bus.i_data_1[XLEN-1] &&
                  (bus.i_funct3 == 3'b001 || bus.i_funct3 == 3'b010 ||
                   bus.i_funct3 == 3'b100 || bus.i_funct3 == 3'b110);
    assign w_s2 = bus.i_data_2[XLEN-1] &&
                  (bus.i_funct3 == 3'b001 || bus.i_funct3 == 3'b100 || bus.i_funct3 == 3'b110);
    assign w_neg  = (bus.i_funct3[2] && bus.i_funct3[1]) ? w_s1 : (w_s1 ^ w_s2);
    assign w_mag1 = cneg(bus.i_data_1, w_s1);
    assign w_mag2 = cneg(bus.i_data_2, w_s2);

    assign w_div0 = w_is_div && (bus.i_data_2 == '0);
    assign w_ovf  = w_is_div && !bus.i_funct3[0] &&
                    (bus.i_data_1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_data_2 == '1);
    assign w_spec_val = w_div0 ? (bus.i_funct3[1] ? bus.i_data_1 : '1)
                               : (bus.i_funct3[1] ? '0 : bus.i_data_1);

    // Multiply: {r_hi,r_lo} shifts right with conditional add. Divide: restoring, quotient into r_lo.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mcand};
    assign w_qbit   = !w_diff[XLEN];
    assign w_hi_nx  = r_funct3[2] ? (w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0])
                                  : w_sum[XLEN:1];
    assign w_lo_nx  = r_funct3[2] ? {r_lo[XLEN-2:0], w_qbit} : {w_sum[0], r_lo[XLEN-1:1]};

    assign w_prod_c = cneg2({w_hi_nx, w_lo_nx}, r_neg);
    assign w_final  = r_funct3[2] ? cneg(r_funct3[1] ? w_hi_nx : w_lo_nx, r_neg)
                    : ((r_funct3[1:0] == 2'b00) ? w_prod_c[XLEN-1:0] : w_prod_c[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= bus.i_funct3;
                        r_tag     <= bus.i_tag;
                        r_neg     <= w_neg;
                        r_special <= w_div0 || w_ovf;
                        r_state   <= S_BUSY;
                        // Special divides skip the iterations and complete on the next edge.
                        if (w_div0 || w_ovf) begin
                            r_result <= w_spec_val;
                            r_cnt    <= CNT_W'(1);
                        end else begin
                            r_cnt    <= CNT_W'(XLEN);
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.i_flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            if (!r_special) r_result <= w_final;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_flush || bus.i_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_mag1 : w_mag2;
            r_mcand <= w_is_div ? w_mag2 : w_mag1;
        end else if (r_state == S_BUSY) begin
            r_hi <= w_hi_nx;
            r_lo <= w_lo_nx;
        end
    end

    assign bus.o_ready  = w_ready;
    assign bus.o_valid  = (r_state == S_DONE);
    assign bus.o_result = r_result;
    assign bus.o_tag    = r_tag;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: 32-bit instance for all ops, handshakes, flush and
// reset, plus a 64-bit instance for the wide multiply.
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_muldiv_if #(.XLEN(32), .TAG_W(5)) b32 ();
    execute_muldiv_if #(.XLEN(64), .TAG_W(5)) b64 ();

    execute_muldiv #(.XLEN(32), .TAG_W(5)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
    execute_muldiv #(.XLEN(64), .TAG_W(5)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [0:11] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32},
        '{3'b101, 32'd100,       32'd7,         32'd14,        32},
        '{3'b111, 32'd100,       32'd7,         32'd2,         32},
        '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32},
        '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32},
        '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32},
        '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
        '{3'b110, 32'd5,         32'd0,         32'd5,         1},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1}
    };

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output int lat, output logic [31:0] res,
                         output logic [4:0] otag);
        @(negedge clk);
        b32.i_valid  = 1'b1;
        b32.i_funct3 = f;
        b32.i_data_1 = a;
        b32.i_data_2 = b;
        b32.i_tag    = tg;
        @(posedge clk);
        #1;
        b32.i_valid  = 1'b0;
        b32.i_data_1 = ~a;
        b32.i_data_2 = ~b;
        b32.i_tag    = ~tg;
        lat = 0;
        while (!b32.o_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        res  = b32.o_result;
        otag = b32.o_tag;
    endtask

    task automatic consume32();
        @(negedge clk);
        b32.i_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (b32.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", b32.o_valid); end
        checks++; if (b32.o_result !== 32'h0) begin failures++; $display("FAIL reset_result got %h want 0", b32.o_result); end
        checks++; if (b32.o_tag !== 5'h0) begin failures++; $display("FAIL reset_tag got %h want 0", b32.o_tag); end
        checks++; if (b32.o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got %b want 0", b32.o_ready); end
        reset = 1'b1;
        #1;
        checks++; if (b32.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rel got %b want 1", b32.o_ready); end
        checks++; if (b64.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready64 got %b want 1", b64.o_ready); end
    endtask

    task automatic test_ops(input int lo, input int hi, input string name);
        int lat;
        logic [31:0] res;
        logic [4:0] tg;
        for (int i = lo; i <= hi; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), lat, res, tg);
            checks++; if (lat !== vecs[i].lat) begin failures++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, vecs[i].lat); end
            checks++; if (res !== vecs[i].exp) begin failures++; $display("FAIL %s[%0d]_result got %h want %h", name, i, res, vecs[i].exp); end
            checks++; if (tg !== 5'(i + 1)) begin failures++; $display("FAIL %s[%0d]_tag got %h want %h", name, i, tg, 5'(i + 1)); end
            consume32();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        logic [4:0] tg;
        do_op(3'b000, 32'h7, 32'hFFFF_FFFD, 5'h15, lat, res, tg);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (b32.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got %b want 1", c, b32.o_valid); end
            checks++; if (b32.o_result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL bp_result[%0d] got %h want ffffffeb", c, b32.o_result); end
            checks++; if (b32.o_tag !== 5'h15) begin failures++; $display("FAIL bp_tag[%0d] got %h want 15", c, b32.o_tag); end
            checks++; if (b32.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got %b want 0", c, b32.o_ready); end
        end
        consume32();
        checks++; if (b32.o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got %b want 1", b32.o_ready); end
        checks++; if (b32.o_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after got %b want 0", b32.o_valid); end
        do_op(3'b101, 32'd100, 32'd7, 5'h16, lat, res, tg);
        checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got %0d want 32", lat); end
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL b2b_result got %h want e", res); end
        checks++; if (tg !== 5'h16) begin failures++; $display("FAIL b2b_tag got %h want 16", tg); end
        consume32();
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] res;
        logic [4:0] tg;
        bit seen;
        @(negedge clk);
        b32.i_valid = 1'b1; b32.i_funct3 = 3'b000; b32.i_data_1 = 32'h7;
        b32.i_data_2 = 32'hFFFF_FFFD; b32.i_tag = 5'h0A;
        @(posedge clk); #1;
        b32.i_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        b32.i_flush = 1'b1;
        @(posedge clk); #1;
        b32.i_flush = 1'b0;
        checks++; if (b32.o_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_ready got %b want 1", b32.o_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (b32.o_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_busy_valid got %b want 0", seen); end
        do_op(3'b101, 32'd9, 32'd3, 5'h0B, lat, res, tg);
        checks++; if (lat !== 32) begin failures++; $display("FAIL flush_next_latency got %0d want 32", lat); end
        checks++; if (res !== 32'd3) begin failures++; $display("FAIL flush_next_result got %h want 3", res); end
        checks++; if (tg !== 5'h0B) begin failures++; $display("FAIL flush_next_tag got %h want 0b", tg); end
        consume32();
        @(negedge clk);
        b32.i_valid = 1'b1; b32.i_flush = 1'b1; b32.i_funct3 = 3'b100;
        b32.i_data_1 = 32'd5; b32.i_data_2 = 32'd0; b32.i_tag = 5'h0C;
        @(posedge clk); #1;
        b32.i_valid = 1'b0; b32.i_flush = 1'b0;
        checks++; if (b32.o_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_ready got %b want 1", b32.o_ready); end
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (b32.o_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_idle_valid got %b want 0", seen); end
        checks++; if (b32.o_tag !== 5'h0B) begin failures++; $display("FAIL flush_idle_tag got %h want 0b", b32.o_tag); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        b32.i_valid = 1'b1; b32.i_funct3 = 3'b101; b32.i_data_1 = 32'd100;
        b32.i_data_2 = 32'd7; b32.i_tag = 5'h1D;
        @(posedge clk); #1;
        b32.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (b32.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", b32.o_valid); end
        checks++; if (b32.o_result !== 32'h0) begin failures++; $display("FAIL rstmid_result got %h want 0", b32.o_result); end
        checks++; if (b32.o_tag !== 5'h0) begin failures++; $display("FAIL rstmid_tag got %h want 0", b32.o_tag); end
        checks++; if (b32.o_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got %b want 0", b32.o_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (b32.o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_rel got %b want 1", b32.o_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (b32.o_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got %b want 0", seen); end
    endtask

    task automatic test_xlen64();
        int lat;
        @(negedge clk);
        b64.i_valid = 1'b1; b64.i_funct3 = 3'b000; b64.i_data_1 = 64'd7;
        b64.i_data_2 = 64'hFFFF_FFFF_FFFF_FFFD; b64.i_tag = 5'h09;
        @(posedge clk); #1;
        b64.i_valid = 1'b0; b64.i_data_1 = '0; b64.i_data_2 = '0;
        lat = 0;
        while (!b64.o_valid && lat < 200) begin @(posedge clk); lat++; #1; end
        checks++; if (lat !== 64) begin failures++; $display("FAIL x64_latency got %0d want 64", lat); end
        checks++; if (b64.o_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL x64_result got %h want ffffffffffffffeb", b64.o_result); end
        checks++; if (b64.o_tag !== 5'h09) begin failures++; $display("FAIL x64_tag got %h want 09", b64.o_tag); end
        @(negedge clk);
        b64.i_ready = 1'b1;
        @(posedge clk); #1;
        b64.i_ready = 1'b0;
        checks++; if (b64.o_ready !== 1'b1) begin failures++; $display("FAIL x64_ready_after got %b want 1", b64.o_ready); end
    endtask

    initial begin
        b32.i_valid = 1'b0; b32.i_funct3 = '0; b32.i_data_1 = '0; b32.i_data_2 = '0;
        b32.i_tag = '0; b32.i_flush = 1'b0; b32.i_ready = 1'b0;
        b64.i_valid = 1'b0; b64.i_funct3 = '0; b64.i_data_1 = '0; b64.i_data_2 = '0;
        b64.i_tag = '0; b64.i_flush = 1'b0; b64.i_ready = 1'b0;
        test_reset();
        test_ops(0, 2, "mul");
        test_ops(3, 7, "divmix");
        test_ops(8, 11, "special");
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
